// File: rtl/int_sequencer_pkg.sv
// Shared types and constants for the interrupt sequencer: FSM states,
// default register addresses and STATUS word bit positions.
package int_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_ENTER,
    S_HANDLER,
    S_EXIT
  } int_state_e;

  localparam logic [31:0] INT_STATUS_ADDR_DFLT = 32'h9000_0038;
  localparam logic [31:0] INT_EPC_ADDR_DFLT    = 32'h9000_003C;

  localparam int unsigned STAT_BUSY       = 0;
  localparam int unsigned STAT_PENDING    = 1;
  localparam int unsigned STAT_IN_HANDLER = 2;
  localparam int unsigned STAT_ERR        = 3;
  localparam int unsigned STAT_MISSED_LSB = 8;
  localparam int unsigned STAT_MISSED_W   = 8;

  function automatic logic [31:0] pack_status(input logic [7:0] missed,
                                              input logic       err,
                                              input logic       in_handler,
                                              input logic       pending,
                                              input logic       busy);
    logic [31:0] w;
    w                                   = '0;
    w[STAT_BUSY]                        = busy;
    w[STAT_PENDING]                     = pending;
    w[STAT_IN_HANDLER]                  = in_handler;
    w[STAT_ERR]                         = err;
    w[STAT_MISSED_LSB +: STAT_MISSED_W] = missed;
    return w;
  endfunction

endpackage

// File: rtl/int_sequencer_if.sv
// CPU readback bus of the interrupt sequencer: read strobe, address and
// registered read data.
interface int_sequencer_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  re;
  logic [DATA_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output re, output addr, input rdata);
  modport slave  (input re, input addr, output rdata);
endinterface

// File: rtl/int_sequencer_readback.sv
// Address decode and registered read-data mux for the sequencer's STATUS
// and EPC words; one cycle of read latency, no read side effects.
module int_readback
  import int_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] STATUS_ADDR = DATA_WIDTH'(INT_STATUS_ADDR_DFLT),
  parameter logic [DATA_WIDTH-1:0] EPC_ADDR    = DATA_WIDTH'(INT_EPC_ADDR_DFLT)
) (
  input  logic                  clock,
  input  logic                  reset,
  int_sequencer_if.slave        bus,
  input  logic [DATA_WIDTH-1:0] status,
  input  logic [DATA_WIDTH-1:0] epc
);

  logic [DATA_WIDTH-1:0] rdata_nxt;

  always_comb begin
    rdata_nxt = '0;
    if (bus.re) begin
      if (bus.addr == STATUS_ADDR) begin
        rdata_nxt = status;
      end else if (bus.addr == EPC_ADDR) begin
        rdata_nxt = epc;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.rdata <= '0;
    end else begin
      bus.rdata <= rdata_nxt;
    end
  end

endmodule

// File: rtl/int_sequencer.sv
// Core-side interrupt sequencer: latches triggers, drains the pipeline,
// redirects to the handler and back on iret. Optional: INT_DRAIN_TIMEOUT_EN.
module int_sequencer
  import int_pkg::*;
#(
  parameter int                    DATA_WIDTH      = 32,
  parameter logic [DATA_WIDTH-1:0] INT_STATUS_ADDR = DATA_WIDTH'(INT_STATUS_ADDR_DFLT),
  parameter logic [DATA_WIDTH-1:0] INT_EPC_ADDR    = DATA_WIDTH'(INT_EPC_ADDR_DFLT),
  parameter int unsigned           DRAIN_TIMEOUT   = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] int_pc,
  input  logic                  int_trigger,
  input  logic                  pipe_empty,
  input  logic [DATA_WIDTH-1:0] commit_pc,
  input  logic                  iret,
  int_sequencer_if.slave        bus,
  output logic                  stall_req,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  in_handler
);

  int_state_e            state, state_nxt;
  logic                  pending;
  logic [7:0]            missed;
  logic                  err;
  logic [DATA_WIDTH-1:0] hpc;
  logic [DATA_WIDTH-1:0] epc;
  logic                  enter;
  logic                  drain_expired;
  logic                  timeout_fire;
  logic [DATA_WIDTH-1:0] status;

`ifdef INT_DRAIN_TIMEOUT_EN
  logic [7:0] drain_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drain_cnt <= '0;
      err       <= 1'b0;
    end else begin
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + 8'd1 : '0;
      if (timeout_fire) begin
        err <= 1'b1;
      end
    end
  end

  assign drain_expired = (drain_cnt == 8'(DRAIN_TIMEOUT - 1));
`else
  logic unused_cfg;

  assign unused_cfg    = (DRAIN_TIMEOUT != 0);
  assign drain_expired = 1'b0;
  assign err           = 1'b0;
`endif

  // pipe_empty wins over an expiring timeout in the same DRAIN cycle
  assign enter        = (state == S_DRAIN) && pipe_empty;
  assign timeout_fire = (state == S_DRAIN) && !pipe_empty && drain_expired;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (pending) state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (enter) begin
          state_nxt = S_ENTER;
        end else if (timeout_fire) begin
          state_nxt = S_IDLE;
        end
      end
      S_ENTER:   state_nxt = S_HANDLER;
      S_HANDLER: if (iret) state_nxt = S_EXIT;
      S_EXIT:    state_nxt = pending ? S_DRAIN : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    stall_req      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    in_handler     = 1'b0;
    unique case (state)
      S_DRAIN:   stall_req = 1'b1;
      S_ENTER: begin
        stall_req      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = hpc;
      end
      S_HANDLER: in_handler = 1'b1;
      S_EXIT: begin
        redirect_valid = 1'b1;
        redirect_pc    = epc;
      end
      default: ;
    endcase
  end

  // a trigger in the same cycle as the clear leaves pending set
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending <= 1'b0;
      missed  <= '0;
      hpc     <= '0;
      epc     <= '0;
    end else begin
      if (int_trigger) begin
        pending <= 1'b1;
        hpc     <= int_pc;
      end else if (enter || timeout_fire) begin
        pending <= 1'b0;
      end
      if (int_trigger && pending && (missed != 8'hFF)) begin
        missed <= missed + 8'd1;
      end
      if (enter) begin
        epc <= commit_pc;
      end
    end
  end

  assign status = DATA_WIDTH'(pack_status(missed, err, state == S_HANDLER,
                                          pending, state != S_IDLE));

  int_readback #(
    .DATA_WIDTH  (DATA_WIDTH),
    .STATUS_ADDR (INT_STATUS_ADDR),
    .EPC_ADDR    (INT_EPC_ADDR)
  ) u_readback (
    .clock  (clock),
    .reset  (reset),
    .bus    (bus),
    .status (status),
    .epc    (epc)
  );

endmodule
